reg_read_scoreboard: RTL and testbench

Read side of the register file, the counterpart of the write-destination select logic. Holds the eight 16-bit general registers, serves two combinational decode-stage read ports, and accepts one write-back port. A per-register pending-write scoreboard stalls decode when a source register still awaits write-back. Sits between decode (reads, issue) and write-back (writes).

---
 rtl/rf_pkg.sv | 9 +
 rtl/rf_scoreboard.sv | 60 ++++++
 rtl/reg_read_scoreboard.sv | 87 ++++++++
 tb/tb_reg_read_scoreboard.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and types.
package rf_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t R7 = 3'd7;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy bits, set/clear priority and
// read hazard detection.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en1,
  input  reg_idx_t            rd_sel1,
  input  logic                rd_en2,
  input  reg_idx_t            rd_sel2,
  input  logic                fwd1,
  input  logic                fwd2,
  input  logic                issue_valid,
  input  reg_idx_t            issue_reg,
  input  logic                wb_en,
  input  reg_idx_t            wb_reg,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                haz1;
  logic                haz2;
  logic                accept;

  always_comb begin
    haz1   = rd_en1 & busy_q[rd_sel1] & ~fwd1;
    haz2   = rd_en2 & busy_q[rd_sel2] & ~fwd2;
    stall  = haz1 | haz2;
    accept = issue_valid & ~stall;
  end

  // Set after clear: a newer write is still outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (wb_en && wb_reg == reg_idx_t'(n)) begin
        busy_d[n] = 1'b0;
      end
      if (accept && issue_reg == reg_idx_t'(n)) begin
        busy_d[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/reg_read_scoreboard.sv
// Register array with two read ports, one write-back port and a
// pending-write scoreboard. Optional forwarding: RF_BYPASS_EN.
module reg_read_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en1,
  input  logic [2:0]          rd_sel1,
  input  logic                rd_en2,
  input  logic [2:0]          rd_sel2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  input  logic                issue_valid,
  input  logic [2:0]          issue_reg,
  input  logic                wb_en,
  input  logic [2:0]          wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              fwd1;
  logic              fwd2;

  always_comb begin
    for (int n = 0; n < NUM_REGS; n++) begin
      regs_d[n] = regs_q[n];
    end
    if (wb_en) begin
      regs_d[wb_reg] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        regs_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_REGS; n++) begin
        regs_q[n] <= regs_d[n];
      end
    end
  end

`ifdef RF_BYPASS_EN
  always_comb begin
    fwd1     = wb_en & (wb_reg == rd_sel1);
    fwd2     = wb_en & (wb_reg == rd_sel2);
    rd_data1 = fwd1 ? wb_data : regs_q[rd_sel1];
    rd_data2 = fwd2 ? wb_data : regs_q[rd_sel2];
  end
`else
  always_comb begin
    fwd1     = 1'b0;
    fwd2     = 1'b0;
    rd_data1 = regs_q[rd_sel1];
    rd_data2 = regs_q[rd_sel2];
  end
`endif

  rf_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en1     (rd_en1),
    .rd_sel1    (rd_sel1),
    .rd_en2     (rd_en2),
    .rd_sel2    (rd_sel2),
    .fwd1       (fwd1),
    .fwd2       (fwd2),
    .issue_valid(issue_valid),
    .issue_reg  (issue_reg),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .stall      (stall),
    .busy       (busy)
  );

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Directed bench for reg_read_scoreboard.
module tb_reg_read_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en1;
  logic [2:0]  rd_sel1;
  logic        rd_en2;
  logic [2:0]  rd_sel2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        issue_valid;
  logic [2:0]  issue_reg;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        stall;
  logic [7:0]  busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_read_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en1     (rd_en1),
    .rd_sel1    (rd_sel1),
    .rd_en2     (rd_en2),
    .rd_sel2    (rd_sel2),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .issue_valid(issue_valid),
    .issue_reg  (issue_reg),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .stall      (stall),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_en1 = 0; rd_sel1 = 0;
    rd_en2 = 0; rd_sel2 = 0;
    issue_valid = 0; issue_reg = 0;
    wb_en = 0; wb_reg = 0; wb_data = 0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      rd_sel1 = 3'(i);
      rd_sel2 = 3'(7 - i);
      #1;
      chk($sformatf("rst_rd1_r%0d", i), 32'(rd_data1), 0);
      chk($sformatf("rst_rd2_r%0d", 7 - i), 32'(rd_data2), 0);
    end
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(stall), 0);

    // issue R3, dependent read
    issue_valid = 1; issue_reg = 3;
    #1;
    chk("iss3_stall", 32'(stall), 0);
    tick();
    issue_valid = 0;
    rd_en1 = 1; rd_sel1 = 3;
    #1;
    chk("dep_stall", 32'(stall), 1);
    chk("dep_busy", 32'(busy), 32'h08);
    tick();
    wb_en = 1; wb_reg = 3; wb_data = 16'hBEEF;
    #1;
`ifdef RF_BYPASS_EN
    chk("wb_cyc_stall", 32'(stall), 0);
    chk("wb_cyc_data", 32'(rd_data1), 32'hBEEF);
`else
    chk("wb_cyc_stall", 32'(stall), 1);
`endif
    tick();
    wb_en = 0;
    #1;
    chk("post_wb_stall", 32'(stall), 0);
    chk("post_wb_data", 32'(rd_data1), 32'hBEEF);
    chk("post_wb_busy", 32'(busy), 0);
    rd_en1 = 0;

    // simultaneous issue + write-back on R5
    issue_valid = 1; issue_reg = 5;
    tick();
    chk("r5_busy", 32'(busy), 32'h20);
    wb_en = 1; wb_reg = 5; wb_data = 16'h0001;
    tick();
    issue_valid = 0; wb_en = 0;
    rd_sel1 = 5;
    #1;
    chk("r5_setwins", 32'(busy), 32'h20);
    chk("r5_data1", 32'(rd_data1), 32'h0001);
    wb_en = 1; wb_reg = 5; wb_data = 16'h0002;
    tick();
    wb_en = 0;
    #1;
    chk("r5_clear", 32'(busy), 0);
    chk("r5_data2", 32'(rd_data1), 32'h0002);

    // stalled issue not recorded
    issue_valid = 1; issue_reg = 2;
    tick();
    rd_en1 = 1; rd_sel1 = 2;
    issue_valid = 1; issue_reg = 6;
    #1;
    chk("st_stall", 32'(stall), 1);
    tick();
    chk("st_busy_a", 32'(busy), 32'h04);
    tick();
    chk("st_busy_b", 32'(busy), 32'h04);
    issue_valid = 0; rd_en1 = 0;
    wb_en = 1; wb_reg = 2; wb_data = 16'h0022;
    tick();
    wb_en = 0;
    #1;
    chk("st_clear", 32'(busy), 0);

    // disabled port, dual ports
    issue_valid = 1; issue_reg = 4;
    tick();
    issue_valid = 0;
    rd_en2 = 0; rd_sel2 = 4;
    #1;
    chk("dis_stall", 32'(stall), 0);
    rd_en2 = 1;
    #1;
    chk("en2_stall", 32'(stall), 1);
    rd_en2 = 0;
    wb_en = 1; wb_reg = 1; wb_data = 16'h1234;
    tick();
    wb_en = 1; wb_reg = 0; wb_data = 16'hA5A5;
    tick();
    wb_en = 0;
    chk("nb_busy", 32'(busy), 32'h10);
    rd_en1 = 1; rd_sel1 = 1;
    rd_en2 = 1; rd_sel2 = 1;
    #1;
    chk("dual_rd1", 32'(rd_data1), 32'h1234);
    chk("dual_rd2", 32'(rd_data2), 32'h1234);
    chk("dual_stall", 32'(stall), 0);
    rd_sel2 = 0;
    #1;
    chk("r0_write", 32'(rd_data2), 32'hA5A5);
    rd_en1 = 0; rd_en2 = 0;

    // reset mid-operation
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1; issue_reg = 3'(i);
      tick();
    end
    issue_valid = 0;
    chk("all_busy", 32'(busy), 32'hFF);
    rst_n = 0;
    wb_en = 1; wb_reg = 7; wb_data = 16'hFFFF;
    tick();
    rst_n = 1; wb_en = 0;
    rd_en1 = 1; rd_sel1 = 7;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_r7", 32'(rd_data1), 0);
    chk("mr_stall", 32'(stall), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
